// File: rtl/crc_pkg.sv
// Shared types and constants for the bit-serial CRC engine.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        READOUT = 2'd2
    } crc_eng_state_t;

    localparam logic [15:0] CRC16_CCITT_POLY  = 16'h1021;
    localparam int          CRC_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/crc_lfsr.sv
// CRC shift register in direct-division (augmented) form with load, absorb and shift-out controls.
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC16_CCITT_POLY),
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_init,
    input  logic             absorb,
    input  logic             shift_out,
    input  logic             data_bit,
    output logic [WIDTH-1:0] value,
    output logic             msb
);

    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] lfsr_next;

    // load_init has priority so a completing or aborted readout always lands on INIT
    always_comb begin
        lfsr_next = lfsr_reg;
        if (load_init) begin
            lfsr_next = INIT;
        end else if (absorb) begin
            lfsr_next = {lfsr_reg[WIDTH-2:0], data_bit} ^ (lfsr_reg[WIDTH-1] ? POLY : '0);
        end else if (shift_out) begin
            lfsr_next = {lfsr_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= INIT;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign value = lfsr_reg;
    assign msb   = lfsr_reg[WIDTH-1];

endmodule

// File: rtl/crc16_serial_engine.sv
// Bit-serial CRC engine: absorbs an augmented message, then shifts the remainder out MSB-first.
module crc16_serial_engine
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC16_CCITT_POLY),
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CLEAR,
    input  logic             SHIFT_EN,
    input  logic             DATA_IN,
    input  logic             READ_MODE,
    output logic             CRC_OUT,
    output logic [WIDTH-1:0] CRC_PARALLEL,
    output logic             CRC_VALID,
    output logic [7:0]       BIT_COUNT,
    output logic             BUSY,
    output logic             PROTO_ERR
);

    localparam int CW = $clog2(WIDTH + 1);

    crc_eng_state_t   state_reg;
    crc_eng_state_t   state_next;
    logic [7:0]       bit_count_reg;
    logic [CW-1:0]    read_cnt_reg;
    logic [WIDTH-1:0] snap_reg;
    logic [WIDTH-1:0] parallel_reg;
    logic             valid_reg;
    logic             err_reg;

    logic [WIDTH-1:0] lfsr_value;
    logic             lfsr_msb;
    logic             strobe;
    logic             last_read;
    logic             do_absorb;
    logic             do_shift;
    logic             do_load;
    logic             do_complete;
    logic             do_abort;
    logic             do_idle_err;
    logic             start_read;

    // CLEAR swallows any simultaneous strobe
    assign strobe    = SHIFT_EN && !CLEAR;
    assign last_read = (read_cnt_reg == CW'(WIDTH - 1));

    crc_lfsr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .load_init (do_load),
        .absorb    (do_absorb),
        .shift_out (do_shift),
        .data_bit  (DATA_IN),
        .value     (lfsr_value),
        .msb       (lfsr_msb)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (CLEAR) begin
            state_next = IDLE;
        end else if (strobe) begin
            case (state_reg)
                IDLE:    if (!READ_MODE) state_next = ACCUM;
                ACCUM:   if (READ_MODE) state_next = READOUT;
                READOUT: if (!READ_MODE || last_read) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        do_absorb   = strobe && !READ_MODE && (state_reg == IDLE || state_reg == ACCUM);
        do_shift    = strobe && READ_MODE && (state_reg == ACCUM || state_reg == READOUT);
        do_complete = strobe && READ_MODE && (state_reg == READOUT) && last_read;
        do_abort    = strobe && !READ_MODE && (state_reg == READOUT);
        do_idle_err = strobe && READ_MODE && (state_reg == IDLE);
        start_read  = strobe && READ_MODE && (state_reg == ACCUM);
        do_load     = CLEAR || do_complete || do_abort;
        CRC_OUT     = READ_MODE && (state_reg == ACCUM || state_reg == READOUT) ? lfsr_msb : 1'b0;
        BUSY        = (state_reg != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bit_count_reg <= '0;
            read_cnt_reg  <= '0;
            snap_reg      <= '0;
            parallel_reg  <= '0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else if (CLEAR) begin
            bit_count_reg <= '0;
            read_cnt_reg  <= '0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            valid_reg <= do_complete;
            if (do_absorb) begin
                if (state_reg == IDLE) begin
                    bit_count_reg <= 8'd1;
                end else if (bit_count_reg != 8'hFF) begin
                    bit_count_reg <= bit_count_reg + 8'd1;
                end
            end
            // The remainder is the whole register at readout entry, before any bit leaves it
            if (start_read) begin
                read_cnt_reg <= CW'(1);
                snap_reg     <= lfsr_value;
            end else if (strobe && state_reg == READOUT) begin
                if (READ_MODE && !last_read) begin
                    read_cnt_reg <= read_cnt_reg + CW'(1);
                end else begin
                    read_cnt_reg <= '0;
                end
            end
            if (do_complete) begin
                parallel_reg <= snap_reg;
            end
            if (do_abort || do_idle_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign CRC_PARALLEL = parallel_reg;
    assign CRC_VALID    = valid_reg;
    assign BIT_COUNT    = bit_count_reg;
    assign PROTO_ERR    = err_reg;

endmodule

// File: tb/tb_crc16_serial_engine.sv
// Directed, scoreboard-based bench for the serial CRC engine.
module tb_crc16_serial_engine;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CLEAR;
    logic        SHIFT_EN;
    logic        DATA_IN;
    logic        READ_MODE;
    logic        CRC_OUT;
    logic [15:0] CRC_PARALLEL;
    logic        CRC_VALID;
    logic [7:0]  BIT_COUNT;
    logic        BUSY;
    logic        PROTO_ERR;

    int          checks   = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_par;

    always #5 CLK = ~CLK;

    crc16_serial_engine dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .CLEAR        (CLEAR),
        .SHIFT_EN     (SHIFT_EN),
        .DATA_IN      (DATA_IN),
        .READ_MODE    (READ_MODE),
        .CRC_OUT      (CRC_OUT),
        .CRC_PARALLEL (CRC_PARALLEL),
        .CRC_VALID    (CRC_VALID),
        .BIT_COUNT    (BIT_COUNT),
        .BUSY         (BUSY),
        .PROTO_ERR    (PROTO_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Augmented division: message followed by 16 zeros, POLY 0x1021, INIT 0
    function automatic logic [15:0] crc_model(input logic [15:0] m);
        logic [15:0] r;
        logic [31:0] s;
        logic        top;
        r = 16'h0000;
        s = {m, 16'h0000};
        for (int i = 31; i >= 0; i--) begin
            top = r[15];
            r   = {r[14:0], s[i]} ^ (top ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    task automatic absorb(input logic d, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                SHIFT_EN = 1'b0;
                cyc();
            end
        end
        SHIFT_EN  = 1'b1;
        DATA_IN   = d;
        READ_MODE = 1'b0;
        cyc();
        SHIFT_EN  = 1'b0;
    endtask

    task automatic send_msg(input logic [15:0] m, input bit gaps);
        for (int i = 15; i >= 0; i--) begin
            absorb(m[i], gaps);
            if (i == 15) begin
                chk("first_bit_count", BIT_COUNT, 1);
                chk("first_bit_busy", BUSY, 1);
            end
        end
        for (int i = 0; i < 16; i++) absorb(1'b0, gaps);
        exp_q.push_back(crc_model(m));
        $display("message %04h absorbed, bit_count=%0d", m, BIT_COUNT);
    endtask

    task automatic read_out();
        logic [15:0] e;
        chk("scoreboard_nonempty", exp_q.size() > 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
        for (int i = 0; i < 16; i++) begin
            SHIFT_EN  = 1'b1;
            READ_MODE = 1'b1;
            #1;
            chk("crc_out_bit", CRC_OUT, e[15-i]);
            cyc();
            if (i < 15) begin
                chk("valid_early", CRC_VALID, 0);
                chk("busy_readout", BUSY, 1);
            end else begin
                chk("valid_done", CRC_VALID, 1);
                chk("parallel_done", CRC_PARALLEL, e);
                chk("busy_done", BUSY, 0);
            end
        end
        SHIFT_EN  = 1'b0;
        READ_MODE = 1'b0;
        last_par  = e;
        $display("readout crc=%04h parallel=%04h", e, CRC_PARALLEL);
    endtask

    initial begin
        RESET_N   = 1'b1;
        CLEAR     = 1'b0;
        SHIFT_EN  = 1'b0;
        DATA_IN   = 1'b0;
        READ_MODE = 1'b0;
        last_par  = 16'h0000;
        #3 RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outputs", {CRC_OUT, CRC_VALID, BUSY, PROTO_ERR, BIT_COUNT, CRC_PARALLEL}, 0);
        RESET_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_outputs", {CRC_OUT, CRC_VALID, BUSY, PROTO_ERR, BIT_COUNT, CRC_PARALLEL}, 0);
        end

        // 0x0001 gapless
        send_msg(16'h0001, 1'b0);
        chk("bit_count_32", BIT_COUNT, 32);
        read_out();
        chk("par_0001", CRC_PARALLEL, 16'h1021);
        cyc();
        chk("valid_single_pulse", CRC_VALID, 0);
        chk("bit_count_hold_idle", BIT_COUNT, 32);

        // 0x0002 with random strobe gaps
        send_msg(16'h0002, 1'b1);
        read_out();
        chk("par_0002_gapped", CRC_PARALLEL, 16'h2042);

        // back-to-back: next message starts on the cycle after completion
        send_msg(16'h8000, 1'b0);
        read_out();
        send_msg(16'hA5C3, 1'b0);
        chk("valid_cleared_b2b", CRC_VALID, 0);
        read_out();
        chk("no_err_yet", PROTO_ERR, 0);

        // abort after 5 readout bits
        send_msg(16'h1234, 1'b0);
        SHIFT_EN  = 1'b1;
        READ_MODE = 1'b1;
        repeat (5) cyc();
        READ_MODE = 1'b0;
        DATA_IN   = 1'b1;
        cyc();
        SHIFT_EN  = 1'b0;
        chk("abort_err", PROTO_ERR, 1);
        chk("abort_idle", BUSY, 0);
        chk("abort_no_valid", CRC_VALID, 0);
        chk("abort_par_kept", CRC_PARALLEL, last_par);
        void'(exp_q.pop_front());
        $display("readout aborted after 5 bits");
        cyc();
        chk("abort_no_valid_late", CRC_VALID, 0);
        send_msg(16'h0001, 1'b0);
        read_out();
        chk("par_after_abort", CRC_PARALLEL, 16'h1021);
        chk("err_sticky", PROTO_ERR, 1);

        // CLEAR clears flags but keeps the parallel result
        CLEAR = 1'b1;
        cyc();
        CLEAR = 1'b0;
        chk("clear_err", PROTO_ERR, 0);
        chk("clear_bit_count", BIT_COUNT, 0);
        chk("clear_par_kept", CRC_PARALLEL, 16'h1021);

        // read strobe in IDLE
        SHIFT_EN  = 1'b1;
        READ_MODE = 1'b1;
        #1;
        chk("idle_crc_out", CRC_OUT, 0);
        cyc();
        SHIFT_EN  = 1'b0;
        READ_MODE = 1'b0;
        chk("idle_read_err", PROTO_ERR, 1);
        chk("idle_read_busy", BUSY, 0);
        chk("idle_read_count", BIT_COUNT, 0);
        $display("read strobe in idle flagged");
        CLEAR = 1'b1;
        cyc();
        CLEAR = 1'b0;
        chk("clear_err2", PROTO_ERR, 0);

        // CLEAR together with the 10th absorb strobe
        for (int i = 0; i < 9; i++) absorb(1'b1, 1'b0);
        chk("nine_bits", BIT_COUNT, 9);
        SHIFT_EN = 1'b1;
        DATA_IN  = 1'b1;
        CLEAR    = 1'b1;
        cyc();
        SHIFT_EN = 1'b0;
        CLEAR    = 1'b0;
        chk("clear_strobe_count", BIT_COUNT, 0);
        chk("clear_strobe_idle", BUSY, 0);
        send_msg(16'h0002, 1'b0);
        read_out();
        chk("par_after_clear", CRC_PARALLEL, 16'h2042);

        // no-strobe hold, then asynchronous reset mid-ACCUM
        for (int i = 0; i < 5; i++) absorb(1'b1, 1'b0);
        READ_MODE = 1'b1;
        repeat (3) cyc();
        READ_MODE = 1'b0;
        chk("hold_count", BIT_COUNT, 5);
        chk("hold_busy", BUSY, 1);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_reset", {CRC_OUT, CRC_VALID, BUSY, PROTO_ERR, BIT_COUNT, CRC_PARALLEL}, 0);
        $display("asynchronous reset mid-message");
        cyc();
        RESET_N = 1'b1;
        cyc();
        send_msg(16'h0001, 1'b0);
        read_out();
        chk("par_after_reset", CRC_PARALLEL, 16'h1021);

        $display("%0d/%0d checks passed", pass_cnt, checks);
        $finish;
    end

endmodule

// File: doc/crc16_serial_engine.md
# crc16_serial_engine

Bit-serial CRC engine that sits directly downstream of the CRC control state machine. It absorbs the serial `DATA_IN` stream, which carries message bits followed by WIDTH augmentation zeros. When `READ_MODE` is asserted it shifts the resulting remainder back out MSB-first on `CRC_OUT`, and it also presents the remainder in parallel with a completion pulse. It uses the augmented shift-register (direct division) form, so appending WIDTH zeros yields the true remainder.

## Interface

Parameters:
- `WIDTH`, 16: CRC register width.
- `POLY`, 16'h1021: generator polynomial, with the implicit x^WIDTH term omitted.
- `INIT`, 16'h0000: register value after reset, CLEAR, or completed readout.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RESET_N`, in, 1: asynchronous, active-low reset.
- `CLEAR`, in, 1: synchronous clear; highest priority after reset.
- `SHIFT_EN`, in, 1: bit strobe; tie high for one bit per cycle.
- `DATA_IN`, in, 1: serial data bit, sampled when `SHIFT_EN` is high and `READ_MODE` is low.
- `READ_MODE`, in, 1: 1 selects the readout direction.
- `CRC_OUT`, out, 1: current readout bit.
- `CRC_PARALLEL`, out, WIDTH: remainder snapshot from the last completed readout.
- `CRC_VALID`, out, 1: one-cycle pulse when a readout completes.
- `BIT_COUNT`, out, 8: number of bits absorbed in the current message; saturates at 255.
- `BUSY`, out, 1: high when the state is not IDLE.
- `PROTO_ERR`, out, 1: sticky protocol-violation flag.

## Operation

States:
- **IDLE**: register holds INIT; read counter is 0.
  - Strobe with `READ_MODE`=0: absorb the bit and go to ACCUM. `BIT_COUNT` becomes 1.
  - Strobe with `READ_MODE`=1: set PROTO_ERR; no other change.
- **ACCUM**: absorb one bit per strobe and increment `BIT_COUNT` (saturating).
  - Strobe with `READ_MODE`=1: shift out the first bit and go to READOUT with read counter 1.
- **READOUT**: each strobe shifts the register left with zero fill and increments the read counter.
  - On the strobe that makes the count equal WIDTH:
    - Capture the remainder into `CRC_PARALLEL`, i.e. the full register value at READOUT entry, snapshotted when readout starts.
    - Pulse `CRC_VALID`.
    - Reload INIT and go to IDLE.
  - Strobe with `READ_MODE`=0 before completion (abort):
    - Set PROTO_ERR.
    - Discard the bit, reload INIT, and go to IDLE.
    - `CRC_PARALLEL` is unchanged and no `CRC_VALID` pulse is produced.

Datapath and output rules:
- Absorb step: `reg <= {reg[WIDTH-2:0], DATA_IN} ^ (reg[WIDTH-1] ? POLY : 0)`.
- `CRC_OUT` is combinational from flops: `reg[WIDTH-1]` when `READ_MODE`=1 and state is ACCUM or READOUT, otherwise 0.
  - The consumer samples `CRC_OUT` on the same edge as the strobe.
- No strobe (`SHIFT_EN`=0): all state holds. `READ_MODE` toggling without a strobe has no effect except on `CRC_OUT`.
- CLEAR (in any state): register=INIT, state=IDLE, counters=0, PROTO_ERR=0. `CRC_PARALLEL` is retained.
- `BIT_COUNT` holds through READOUT and IDLE. It resets only on reset, CLEAR, or a new message start.

## Timing

- Reset values: `CRC_OUT`=0, `CRC_PARALLEL`=0, `CRC_VALID`=0, `BIT_COUNT`=0, `BUSY`=0, `PROTO_ERR`=0. State is IDLE and the register holds INIT.
- Latency: an absorbed bit affects the register one edge after its strobe.
- `CRC_VALID` and the new `CRC_PARALLEL` value appear together one edge after the WIDTH-th read strobe; `BUSY` drops at the same edge.
- CLEAR in the same cycle as a strobe: CLEAR wins and the bit is discarded.
- Reset assertion mid-operation: all outputs return to reset values immediately, with no clock required.
- Back-to-back messages: a strobe in the cycle after completion starts a new ACCUM with no dead cycle.

## Structure

- Package `crc_pkg` holds:
  - the state enum `crc_eng_state_t` (IDLE, ACCUM, READOUT);
  - `CRC16_CCITT_POLY` = 16'h1021;
  - the default WIDTH constant.
- One sub-module, `crc_lfsr`: the WIDTH-bit register with load-INIT, absorb-step, and shift-out controls, plus an MSB tap. The top level contains the FSM, counters, and flags.

## Test plan

- Reset, then idle for 10 cycles: all outputs stay at 0 and `BUSY`=0. Assert `RESET_N` low mid-ACCUM: outputs return to 0 asynchronously.
- Absorb 0x0001 MSB-first, then 16 zeros, then read 16 bits: `CRC_OUT` sequence is 0x1021 MSB-first, `CRC_PARALLEL`=0x1021, a single `CRC_VALID` pulse, and `BIT_COUNT`=32.
- Absorb 0x0002 plus 16 zeros with random `SHIFT_EN` gaps: result is 0x2042, identical to the gapless run.
- Start readout, then drop `READ_MODE` with a strobe after 5 bits: PROTO_ERR=1, state returns to IDLE, no `CRC_VALID`, and `CRC_PARALLEL` is unchanged. The next 0x0001 message still yields 0x1021.
- Strobe with `READ_MODE`=1 in IDLE: PROTO_ERR=1 and `BUSY` stays 0. Assert CLEAR: PROTO_ERR=0.
- Assert CLEAR together with the 10th absorb strobe: register returns to INIT, `BIT_COUNT`=0, and the state is IDLE.
